// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: merges ALU and buffered MDU results onto the GPR write port, with WAW kill and RAW hazard reporting
module gpr_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          alu_ovf,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [4:0]    mdu_rd,
  input  logic [31:0]   mdu_data,
  input  logic [4:0]    rd_a,
  input  logic [4:0]    rd_b,
  output logic          hazard_a,
  output logic          hazard_b,
  output logic [4:0]    rW,
  output logic [31:0]   busW,
  output logic          GPR_Wr,
  output logic [1:0]    GPR_sel,
  output logic [AW:0]   fifo_count
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop, w_kill, w_push_vld, w_hit_a, w_hit_b, w_out_live;
  assign mdu_ready  = r_cnt != FULL;
  assign fifo_count = r_cnt;
  assign w_push     = mdu_valid && mdu_ready;
  assign w_pop      = !alu_valid && r_cnt != '0;
  assign w_kill     = alu_valid && alu_rd != 5'd0 && !alu_ovf;
  assign w_push_vld = mdu_rd != 5'd0 && !(w_kill && mdu_rd == alu_rd);
  assign w_out_live = GPR_Wr && GPR_sel != 2'b11;
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit_a = w_hit_a | (r_vld[i] && r_rd[i] == rd_a);
      w_hit_b = w_hit_b | (r_vld[i] && r_rd[i] == rd_b);
    end
    hazard_a = rd_a != 5'd0 && (w_hit_a || (w_out_live && rW == rd_a));
    hazard_b = rd_b != 5'd0 && (w_hit_b || (w_out_live && rW == rd_b));
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wp]   <= mdu_rd;
      r_data[r_wp] <= mdu_data;
    end
  end
  // popped slots are cleared so only occupied entries can match a hazard or kill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      rW      <= '0;
      busW    <= '0;
      GPR_Wr  <= 1'b0;
      GPR_sel <= 2'b00;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_kill && r_rd[i] == alu_rd) r_vld[i] <= 1'b0;
      if (w_pop) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= r_rp + 1'b1;
      end
      if (w_push) begin
        r_vld[r_wp] <= w_push_vld;
        r_wp        <= r_wp + 1'b1;
      end
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (alu_valid) begin
        rW      <= alu_rd;
        busW    <= alu_data;
        GPR_Wr  <= alu_ovf || alu_rd != 5'd0;
        GPR_sel <= alu_ovf ? 2'b11 : 2'b00;
      end else if (w_pop) begin
        rW      <= r_rd[r_rp];
        busW    <= r_data[r_rp];
        GPR_Wr  <= r_vld[r_rp];
        GPR_sel <= 2'b00;
      end else begin
        GPR_Wr  <= 1'b0;
      end
    end
  end
endmodule
